// File: rtl/regfile_sweep_reader.sv
// Sweeps a dual-read-port register file in ascending address order, streams each
// word out on valid/ready and counts words that differ from a latched expected value.
module regfile_sweep_reader #(
  parameter int NUM_REGS  = 64,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] expected_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [ADDR_W-1:0] first_mismatch_addr,
  output logic [1:0]        rf_read_en,
  output logic [ADDR_W-1:0] rf_raddr_0,
  output logic [ADDR_W-1:0] rf_raddr_1,
  input  logic [DATA_W-1:0] rf_rdata_0,
  input  logic [DATA_W-1:0] rf_rdata_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_REGS - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] issue_addr;
  logic              inflight;
  logic [ADDR_W-1:0] cap_addr, cap_addr_1;
  logic [DATA_W-1:0] exp_val;
  logic [DATA_W-1:0] buf_data [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_addr [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_p1;
  logic [CNT_W-1:0]  count, count_nxt, wr_n;
  logic [CNT_W+1:0]  issue_need;
  logic              issue_ok, last_pair;
  logic              pop, pop_buf, pop_byp, bypass;
  logic              mis0, mis1;
  logic [ADDR_W+1:0] mis_sum;
  logic [ADDR_W:0]   mis_sat;

  // Stream handshake: a beat transfers on any cycle with out_valid && out_ready;
  // once out_valid rises, out_addr/out_data hold until that transfer.
  // With an empty buffer, port-0 data landing this cycle is presented directly.
  assign bypass    = (count == '0) && inflight;
  assign out_valid = (count != '0) || inflight;
  assign out_addr  = (count != '0) ? buf_addr[rd_ptr] : (inflight ? cap_addr : '0);
  assign out_data  = (count != '0) ? buf_data[rd_ptr] : (inflight ? rf_rdata_0 : '0);
  assign pop       = out_valid && out_ready;
  assign pop_buf   = pop && (count != '0);
  assign pop_byp   = pop && bypass;

  assign cap_addr_1 = {cap_addr[ADDR_W-1:1], 1'b1};
  assign wr_ptr_p1  = wr_ptr + PTR_W'(1);
  assign wr_n       = inflight ? (pop_byp ? CNT_W'(1) : CNT_W'(2)) : '0;
  assign count_nxt  = count + wr_n - CNT_W'(pop_buf);

  // Reserve room for words already in flight plus the pair about to issue.
  assign issue_need = {2'b00, count} + (inflight ? (CNT_W+2)'(4) : (CNT_W+2)'(2));
  assign issue_ok   = (state == S_ISSUE) && (issue_need <= (CNT_W+2)'(BUF_DEPTH));
  assign last_pair  = (issue_addr == LAST_PAIR);

  assign mis0    = (rf_rdata_0 != exp_val);
  assign mis1    = (rf_rdata_1 != exp_val);
  assign mis_sum = {1'b0, mismatch_cnt} + (ADDR_W+2)'(mis0) + (ADDR_W+2)'(mis1);
  assign mis_sat = mis_sum[ADDR_W+1] ? '1 : mis_sum[ADDR_W:0];

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    rf_read_en = 2'b00;
    rf_raddr_0 = '0;
    rf_raddr_1 = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy       = 1'b1;
        rf_raddr_0 = issue_addr;
        rf_raddr_1 = {issue_addr[ADDR_W-1:1], 1'b1};
        if (issue_ok) begin
          rf_read_en = 2'b11;
          if (last_pair) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!inflight && count_nxt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      issue_addr          <= '0;
      inflight            <= 1'b0;
      cap_addr            <= '0;
      exp_val             <= '0;
      mismatch_cnt        <= '0;
      first_mismatch_addr <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue_ok;
      wr_ptr   <= wr_ptr + PTR_W'(wr_n);
      count    <= count_nxt;
      if (pop_buf) rd_ptr <= rd_ptr + PTR_W'(1);
      if (issue_ok) begin
        cap_addr <= issue_addr;
        if (!last_pair) issue_addr <= issue_addr + ADDR_W'(2);
      end
      if (state == S_IDLE && start) begin
        exp_val             <= expected_val;
        issue_addr          <= '0;
        mismatch_cnt        <= '0;
        first_mismatch_addr <= '0;
      end else if (inflight) begin
        mismatch_cnt <= mis_sat;
        // Saturation never returns to zero, so zero means no mismatch yet.
        if (mismatch_cnt == '0 && mis0) first_mismatch_addr <= cap_addr;
        else if (mismatch_cnt == '0 && mis1) first_mismatch_addr <= cap_addr_1;
      end
    end
  end

  // Port 0 is always ordered ahead of port 1; a bypassed port-0 word is not stored.
  always_ff @(posedge clk) begin
    if (inflight) begin
      if (pop_byp) begin
        buf_data[wr_ptr] <= rf_rdata_1;
        buf_addr[wr_ptr] <= cap_addr_1;
      end else begin
        buf_data[wr_ptr]    <= rf_rdata_0;
        buf_addr[wr_ptr]    <= cap_addr;
        buf_data[wr_ptr_p1] <= rf_rdata_1;
        buf_addr[wr_ptr_p1] <= cap_addr_1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sweep_reader.sv
// Bench for regfile_sweep_reader: behavioural register file, scoreboard of expected
// beats, and one task per scenario.
module tb_regfile_sweep_reader;
  localparam int NUM_REGS  = 64;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 4;
  localparam int BEAT_W    = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] expected_val = '0;
  logic              busy, done, out_valid;
  logic [ADDR_W:0]   mismatch_cnt;
  logic [ADDR_W-1:0] first_mismatch_addr, rf_raddr_0, rf_raddr_1, out_addr;
  logic [1:0]        rf_read_en;
  logic [DATA_W-1:0] rf_rdata_0 = '0;
  logic [DATA_W-1:0] rf_rdata_1 = '0;
  logic [DATA_W-1:0] out_data;

  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  logic [BEAT_W-1:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int beat_cnt, first_beat_cyc, last_beat_cyc, gap_cnt;
  int done_cnt, done_cyc, issue_cnt, words_iss, overflow_cnt;
  logic              hold_pending = 1'b0;
  logic [BEAT_W-1:0] held_beat;

  regfile_sweep_reader #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .expected_val(expected_val),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .first_mismatch_addr(first_mismatch_addr), .rf_read_en(rf_read_en),
    .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (rf_read_en[0]) rf_rdata_0 <= rf_mem[rf_raddr_0];
    if (rf_read_en[1]) rf_rdata_1 <= rf_mem[rf_raddr_1];
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [BEAT_W-1:0] got, want;
    if (!reset_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        vectors++;
        if (out_valid !== 1'b1 || {out_addr, out_data} !== held_beat) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%0b beat=%h, required valid=1 beat=%h",
                   out_valid, {out_addr, out_data}, held_beat);
        end
      end
      if (rf_read_en == 2'b11) begin
        issue_cnt++;
        words_iss += 2;
      end
      if (words_iss - beat_cnt > BUF_DEPTH) overflow_cnt++;
      if (out_valid && out_ready) begin
        got = {out_addr, out_data};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected: got addr=%0d data=%h, required no beat", out_addr, out_data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL beat: got addr=%0d data=%h, required addr=%0d data=%h",
                     got[BEAT_W-1:DATA_W], got[DATA_W-1:0], want[BEAT_W-1:DATA_W], want[DATA_W-1:0]);
          end
        end
        if (beat_cnt == 0) first_beat_cyc = cyc;
        else if (cyc != last_beat_cyc + 1) gap_cnt++;
        last_beat_cyc = cyc;
        beat_cnt++;
      end
      hold_pending = out_valid && !out_ready;
      held_beat    = {out_addr, out_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beat_cnt = 0; first_beat_cyc = 0; last_beat_cyc = 0; gap_cnt = 0;
    done_cnt = 0; done_cyc = 0; issue_cnt = 0; words_iss = 0; overflow_cnt = 0;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back({ADDR_W'(i), rf_mem[i]});
  endtask

  task automatic pulse_start(input logic [DATA_W-1:0] ev, output int s_cyc);
    expected_val = ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required done=1", name, done, budget);
    end
  endtask

  function automatic int model_mis(input logic [DATA_W-1:0] ev);
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) if (rf_mem[i] !== ev) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [DATA_W-1:0] ev);
    for (int i = 0; i < NUM_REGS; i++) if (rf_mem[i] !== ev) return i;
    return 0;
  endfunction

  task automatic check_sweep_end(input string name, input logic [DATA_W-1:0] ev);
    vectors++;
    if (beat_cnt !== NUM_REGS || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_beats: got %0d beats (%0d left), required %0d (0 left)",
               name, beat_cnt, exp_q.size(), NUM_REGS);
    end
    vectors++;
    if (mismatch_cnt !== (ADDR_W+1)'(model_mis(ev))) begin
      miscompares++;
      $display("FAIL %s_mismatch_cnt: got %0d, required %0d", name, mismatch_cnt, model_mis(ev));
    end
    vectors++;
    if (first_mismatch_addr !== ADDR_W'(model_first(ev))) begin
      miscompares++;
      $display("FAIL %s_first_addr: got %0d, required %0d", name, first_mismatch_addr, model_first(ev));
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({busy, done, out_valid, rf_read_en} !== 5'b0 || mismatch_cnt !== '0 ||
        first_mismatch_addr !== '0) begin
      miscompares++;
      $display("FAIL %s_ctrl: got busy=%0b done=%0b valid=%0b en=%b cnt=%0d first=%0d, required all 0",
               name, busy, done, out_valid, rf_read_en, mismatch_cnt, first_mismatch_addr);
    end
    vectors++;
    if ({rf_raddr_0, rf_raddr_1, out_addr, out_data} !== '0) begin
      miscompares++;
      $display("FAIL %s_buses: got raddr0=%0d raddr1=%0d out_addr=%0d out_data=%h, required 0",
               name, rf_raddr_0, rf_raddr_1, out_addr, out_data);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_defaults();
    int s;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    out_ready = 1'b1;
    clear_stats();
    push_sweep();
    pulse_start('0, s);
    wait_done("defaults", 300);
    tick();
    check_sweep_end("defaults", '0);
    vectors++;
    if (first_beat_cyc !== s + 1 || last_beat_cyc !== s + NUM_REGS || gap_cnt !== 0) begin
      miscompares++;
      $display("FAIL defaults_timing: got first=%0d last=%0d gaps=%0d, required first=%0d last=%0d gaps=0",
               first_beat_cyc, last_beat_cyc, gap_cnt, s + 1, s + NUM_REGS);
    end
    vectors++;
    if (done_cyc !== s + NUM_REGS + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL defaults_done_cycle: got done_cyc=%0d busy=%0b, required %0d busy=0",
               done_cyc, busy, s + NUM_REGS + 1);
    end
  endtask

  task automatic test_pattern();
    int s;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = DATA_W'(i * 3);
    out_ready = 1'b1;
    clear_stats();
    push_sweep();
    pulse_start('0, s);
    wait_done("pattern", 300);
    tick();
    check_sweep_end("pattern", '0);
    vectors++;
    if (mismatch_cnt !== 7'd63 || first_mismatch_addr !== 6'd1) begin
      miscompares++;
      $display("FAIL pattern_fixed: got cnt=%0d first=%0d, required cnt=63 first=1",
               mismatch_cnt, first_mismatch_addr);
    end
  endtask

  task automatic test_backpressure();
    int s;
    logic [DATA_W-1:0] ev;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
    ev = rf_mem[7];
    out_ready = 1'b0;
    clear_stats();
    push_sweep();
    pulse_start(ev, s);
    repeat (50) tick();
    vectors++;
    if (issue_cnt !== 2 || beat_cnt !== 0) begin
      miscompares++;
      $display("FAIL bp_issue: got pairs=%0d beats=%0d, required pairs=2 beats=0", issue_cnt, beat_cnt);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_addr !== '0 || rf_read_en !== 2'b00) begin
      miscompares++;
      $display("FAIL bp_stall: got valid=%0b addr=%0d en=%b, required valid=1 addr=0 en=00",
               out_valid, out_addr, rf_read_en);
    end
    out_ready = 1'b1;
    wait_done("backpressure", 300);
    tick();
    check_sweep_end("backpressure", ev);
  endtask

  task automatic test_toggle();
    int s;
    int n = 0;
    logic [DATA_W-1:0] ev;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom_range(0, 3);
    ev = DATA_W'($urandom_range(0, 3));
    out_ready = 1'b1;
    clear_stats();
    push_sweep();
    pulse_start(ev, s);
    while (done !== 1'b1 && n < 400) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL toggle_timeout: done=%0b after 400 cycles, required done=1", done);
    end
    out_ready = 1'b1;
    tick();
    check_sweep_end("toggle", ev);
    vectors++;
    if (overflow_cnt !== 0) begin
      miscompares++;
      $display("FAIL toggle_overflow: got %0d over-occupancy cycles, required 0", overflow_cnt);
    end
  endtask

  task automatic test_restart();
    int s, s2;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = DATA_W'(i * 3);
    out_ready = 1'b1;
    clear_stats();
    push_sweep();
    pulse_start('0, s);
    repeat (9) tick();
    expected_val = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("restart_a", 300);
    tick();
    check_sweep_end("restart_a", '0);
    clear_stats();
    push_sweep();
    pulse_start(32'd6, s2);
    vectors++;
    if (mismatch_cnt !== '0 || first_mismatch_addr !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear: got cnt=%0d first=%0d busy=%0b, required 0 0 1",
               mismatch_cnt, first_mismatch_addr, busy);
    end
    wait_done("restart_b", 300);
    tick();
    check_sweep_end("restart_b", 32'd6);
  endtask

  task automatic test_reset_mid();
    int s;
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
    out_ready = 1'b1;
    clear_stats();
    push_sweep();
    pulse_start('0, s);
    while (beat_cnt < 21 && n < 200) begin
      tick();
      n++;
    end
    if (beat_cnt < 21) begin
      vectors++;
      miscompares++;
      $display("FAIL midreset_timeout: got %0d beats, required 21", beat_cnt);
    end
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    repeat (5) tick();
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++;
      $display("FAIL midreset_done: got %0d done pulses, required 0", done_cnt);
    end
    reset_n = 1'b1;
    tick();
    clear_stats();
    push_sweep();
    pulse_start('0, s);
    wait_done("midreset", 300);
    tick();
    check_sweep_end("midreset", '0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_defaults();
    test_pattern();
    test_backpressure();
    test_toggle();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
